// File: rtl/busio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : busio_pkg
// Description : Shared types and constants for the external-bus I/O port
// Revision    : 1.0 - initial release
// ============================================================================
package busio_pkg;

    // Register index on the arx select, shared with the bus arbiter
    typedef enum logic [1:0] {
        REG_ADDR  = 2'd0,
        REG_CMD   = 2'd1,
        REG_RDATA = 2'd2,
        REG_WDATA = 2'd3
    } reg_index;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2
    } port_state;

    localparam int c_timeout_default = 255;

endpackage
`default_nettype wire

// File: rtl/busio_timer.sv
`default_nettype none
// ============================================================================
// Module      : busio_timer
// Description : 8-bit memory-acknowledge wait counter with expiry flag
// Revision    : 1.0 - initial release
// ============================================================================
module busio_timer
    import busio_pkg::*;
#(
    parameter int TIMEOUT = c_timeout_default
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] c_last = 8'(TIMEOUT - 1);

    logic [7:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 8'd1;
        end
    end

    // Fires on the edge at which the count would step onto TIMEOUT
    assign expired = enable && !clear && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/busio_port.sv
`default_nettype none
// ============================================================================
// Module      : busio_port
// Description : External-bus exchange registers with memory read/write
//               handshake, timeout, address auto-increment and bus lock
// Revision    : 1.0 - initial release
// ============================================================================
module busio_port
    import busio_pkg::*;
#(
    parameter int AW      = 20,
    parameter int DW      = 64,
    parameter int TIMEOUT = c_timeout_default
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [1:0]    arx,
    input  logic          ecx,
    input  logic          wrx,
    input  logic          astb,
    input  logic          atomic,
    input  logic          rd,
    input  logic          wr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          busy,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic          mem_lock,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_cmd;
    logic [DW-1:0] r_rdata;
    logic [DW-1:0] r_wdata;
    port_state     r_state;
    logic          r_rd_to_cmd;
    logic          r_busy;
    logic          r_err;
    logic          r_mem_req;
    logic          r_mem_we;
    logic          r_mem_lock;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;

    reg_index      w_idx;
    logic          w_rd_req;
    logic          w_wr_req;
    logic          w_load;
    logic          w_start;
    logic          w_timeout;
    logic [DW-1:0] w_dout;

    assign w_idx    = reg_index'(arx);
    assign w_rd_req = ecx & rd;
    assign w_wr_req = ecx & wr;
    assign w_load   = ecx & ~wrx & ~rd & ~wr;
    assign w_start  = (r_state == ST_IDLE) & (w_rd_req | w_wr_req);

    busio_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_start),
        .enable  (r_busy),
        .expired (w_timeout)
    );

    always_comb begin
        w_dout = '0;
        if (ecx && wrx) begin
            case (w_idx)
                REG_ADDR:  w_dout = DW'(r_addr);
                REG_CMD:   w_dout = r_cmd;
                REG_RDATA: w_dout = r_rdata;
                REG_WDATA: w_dout = r_wdata;
                default:   w_dout = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= '0;
            r_cmd       <= '0;
            r_rdata     <= '0;
            r_wdata     <= '0;
            r_state     <= ST_IDLE;
            r_rd_to_cmd <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_lock  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (astb && atomic) begin
                r_mem_lock <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_rd_req || w_wr_req) begin
                        // Request address/data are snapshots, so later loads cannot disturb the bus
                        r_mem_req   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= r_wdata;
                        if (w_rd_req) begin
                            r_state     <= ST_RD_WAIT;
                            r_mem_we    <= 1'b0;
                            r_rd_to_cmd <= (w_idx == REG_CMD);
                            if (w_wr_req) begin
                                r_err <= 1'b1;
                            end
                        end else begin
                            r_state  <= ST_WR_WAIT;
                            r_mem_we <= 1'b1;
                        end
                    end
                end

                ST_RD_WAIT, ST_WR_WAIT: begin
                    if (w_rd_req || w_wr_req) begin
                        r_err <= 1'b1;
                    end
                    if (mem_ack) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                        r_busy    <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_addr    <= r_addr + AW'(1);
                        if (r_state == ST_RD_WAIT) begin
                            if (r_rd_to_cmd) begin
                                r_cmd <= mem_rdata;
                            end else begin
                                r_rdata <= mem_rdata;
                            end
                        end else begin
                            r_mem_lock <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_state    <= ST_IDLE;
                        r_mem_req  <= 1'b0;
                        r_busy     <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_err      <= 1'b1;
                        r_mem_lock <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // An explicit load takes priority over the post-transfer increment
            if (w_load) begin
                case (w_idx)
                    REG_ADDR:  r_addr  <= din[AW-1:0];
                    REG_WDATA: r_wdata <= din;
                    default:   ;
                endcase
            end
        end
    end

    assign dout      = w_dout;
    assign busy      = r_busy;
    assign err       = r_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_lock  = r_mem_lock;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire
